// File: rtl/game_round_ctrl.sv
// Timed round controller: captures the first qualifying player result onto LED,
// holds it for HOLD_CYCLES, and flags timeouts. Optional per-player score: SCORE_EN.
module game_round_ctrl #(
   parameter int NUM_PLAYERS  = 2,
   parameter int RESULT_W     = 3,
   parameter int ROUND_CYCLES = 1000,
   parameter int HOLD_CYCLES  = 500,
   parameter int SEL_W        = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            start,
   input  logic                            abort,
   input  logic [1:0]                      mode,
   input  logic [SEL_W-1:0]                player_sel,
   input  logic [NUM_PLAYERS-1:0]          enable,
   input  logic [NUM_PLAYERS-1:0]          done_valid,
   input  logic [NUM_PLAYERS*RESULT_W-1:0] done,
`ifdef SCORE_EN
   input  logic                            score_clr,
   output logic [NUM_PLAYERS*4-1:0]        score,
`endif
   output logic [RESULT_W-1:0]             LED,
   output logic [SEL_W-1:0]                winner,
   output logic                            round_active,
   output logic                            time_out,
   output logic                            result_valid
);

   localparam int MAX_CYC = (ROUND_CYCLES > HOLD_CYCLES) ? ROUND_CYCLES : HOLD_CYCLES;
   localparam int TW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
   localparam logic [TW-1:0] ROUND_LOAD = TW'(ROUND_CYCLES - 1);
   localparam logic [TW-1:0] HOLD_LOAD  = TW'(HOLD_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_PLAY = 2'd1,
      ST_SHOW = 2'd2,
      ST_TOUT = 2'd3
   } state_t;

   state_t                   state_r, state_nxt_s;
   logic [TW-1:0]            timer_r, timer_nxt_s;
   logic [1:0]               mode_r, mode_nxt_s;
   logic [SEL_W-1:0]         sel_r, sel_nxt_s;
   logic [RESULT_W-1:0]      led_r, led_nxt_s;
   logic [SEL_W-1:0]         winner_r, winner_nxt_s;
   logic                     round_active_r, time_out_r, result_valid_r;
   logic                     start_ok_s, timer_zero_s, any_qual_s;
   logic [NUM_PLAYERS-1:0]   elig_s, qual_s;
   logic [SEL_W-1:0]         win_s;
   logic [RESULT_W-1:0]      win_led_s;

   assign start_ok_s   = start && (mode != 2'b10);
   assign timer_zero_s = (timer_r == TW'(0));
   assign qual_s       = elig_s & enable & done_valid;
   assign any_qual_s   = |qual_s;

   // Eligible player mask from the mode latched at round start
   always_comb begin
      elig_s = {NUM_PLAYERS{1'b0}};
      case (mode_r)
         2'b00: elig_s[0] = 1'b1;
         2'b01: begin
            for (int i = 0; i < NUM_PLAYERS; i++) begin
               if (sel_r == SEL_W'(i)) begin
                  elig_s[i] = 1'b1;
               end else begin
                  elig_s[i] = 1'b0;
               end
            end
         end
         2'b11:   elig_s = {NUM_PLAYERS{1'b1}};
         default: elig_s = {NUM_PLAYERS{1'b0}};
      endcase
   end

   // Lowest qualifying index wins; scan downward so the lowest is written last
   always_comb begin
      win_s     = {SEL_W{1'b0}};
      win_led_s = {RESULT_W{1'b0}};
      for (int i = NUM_PLAYERS - 1; i >= 0; i--) begin
         if (qual_s[i]) begin
            win_s     = SEL_W'(i);
            win_led_s = done[i*RESULT_W +: RESULT_W];
         end else begin
            win_s     = win_s;
            win_led_s = win_led_s;
         end
      end
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state logic; abort outranks capture, capture outranks timeout
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (start_ok_s) state_nxt_s = ST_PLAY;
            else            state_nxt_s = ST_IDLE;
         end
         ST_PLAY: begin
            if (abort)             state_nxt_s = ST_IDLE;
            else if (any_qual_s)   state_nxt_s = ST_SHOW;
            else if (timer_zero_s) state_nxt_s = ST_TOUT;
            else                   state_nxt_s = ST_PLAY;
         end
         ST_SHOW, ST_TOUT: begin
            if (abort || timer_zero_s) state_nxt_s = ST_IDLE;
            else                       state_nxt_s = state_r;
         end
         default: state_nxt_s = ST_IDLE;
      endcase
   end

   // Next values for the timer, latched round config and registered outputs
   always_comb begin
      timer_nxt_s  = timer_r;
      mode_nxt_s   = mode_r;
      sel_nxt_s    = sel_r;
      led_nxt_s    = led_r;
      winner_nxt_s = winner_r;
      case (state_r)
         ST_IDLE: begin
            led_nxt_s = {RESULT_W{1'b0}};
            if (start_ok_s) begin
               timer_nxt_s = ROUND_LOAD;
               mode_nxt_s  = mode;
               sel_nxt_s   = player_sel;
            end else begin
               timer_nxt_s = timer_r;
            end
         end
         ST_PLAY: begin
            if (abort) begin
               timer_nxt_s = TW'(0);
               led_nxt_s   = {RESULT_W{1'b0}};
               mode_nxt_s  = 2'b00;
               sel_nxt_s   = {SEL_W{1'b0}};
            end else if (any_qual_s) begin
               led_nxt_s    = win_led_s;
               winner_nxt_s = win_s;
               timer_nxt_s  = HOLD_LOAD;
            end else if (timer_zero_s) begin
               timer_nxt_s = HOLD_LOAD;
            end else begin
               timer_nxt_s = timer_r - TW'(1);
            end
         end
         ST_SHOW, ST_TOUT: begin
            if (abort || timer_zero_s || (state_r == ST_TOUT)) begin
               led_nxt_s = {RESULT_W{1'b0}};
            end else begin
               led_nxt_s = led_r;
            end
            if (abort || timer_zero_s) begin
               timer_nxt_s = TW'(0);
            end else begin
               timer_nxt_s = timer_r - TW'(1);
            end
            if (abort) begin
               mode_nxt_s = 2'b00;
               sel_nxt_s  = {SEL_W{1'b0}};
            end else begin
               mode_nxt_s = mode_r;
               sel_nxt_s  = sel_r;
            end
         end
         default: begin
            timer_nxt_s = TW'(0);
            led_nxt_s   = {RESULT_W{1'b0}};
         end
      endcase
   end

   // Output and datapath registers
   always_ff @(posedge clk) begin
      if (rst) begin
         timer_r        <= TW'(0);
         mode_r         <= 2'b00;
         sel_r          <= {SEL_W{1'b0}};
         led_r          <= {RESULT_W{1'b0}};
         winner_r       <= {SEL_W{1'b0}};
         round_active_r <= 1'b0;
         time_out_r     <= 1'b0;
         result_valid_r <= 1'b0;
      end else begin
         timer_r        <= timer_nxt_s;
         mode_r         <= mode_nxt_s;
         sel_r          <= sel_nxt_s;
         led_r          <= led_nxt_s;
         winner_r       <= winner_nxt_s;
         round_active_r <= (state_nxt_s == ST_PLAY);
         time_out_r     <= (state_nxt_s == ST_TOUT);
         result_valid_r <= (state_nxt_s == ST_SHOW);
      end
   end

   assign LED          = led_r;
   assign winner       = winner_r;
   assign round_active = round_active_r;
   assign time_out     = time_out_r;
   assign result_valid = result_valid_r;

`ifdef SCORE_EN
   logic [NUM_PLAYERS*4-1:0] score_r;
   logic                     score_inc_s;

   assign score_inc_s = (state_r == ST_PLAY) && (state_nxt_s == ST_SHOW);

   // Saturating per-player win counters; clear beats a same-cycle increment
   always_ff @(posedge clk) begin
      if (rst || score_clr) begin
         score_r <= {(NUM_PLAYERS*4){1'b0}};
      end else begin
         for (int i = 0; i < NUM_PLAYERS; i++) begin
            if (score_inc_s && (win_s == SEL_W'(i)) && (score_r[i*4 +: 4] != 4'hF)) begin
               score_r[i*4 +: 4] <= score_r[i*4 +: 4] + 4'd1;
            end else begin
               score_r[i*4 +: 4] <= score_r[i*4 +: 4];
            end
         end
      end
   end

   assign score = score_r;
`endif

endmodule
